mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the processor's single-port 16-bit instruction/data memory between the multicycle control unit (CPU port) and a host loader/debug port (HOST port). It sequences each access as a two-phase issue/complete transaction against a synchronous block RAM with one-cycle read latency. It holds read data for the requester and raises a wait signal that freezes the control unit's state register until its access completes.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- HOST_PRIORITY, 0, IDLE-arbitration winner on simultaneous requests (0 = CPU wins, 1 = HOST wins)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- CpuReq  in  1  CPU access request (MRead | MWrite), held until CpuAck
- CpuWe  in  1  1 = write, 0 = read; stable while CpuReq
- CpuAddr  in  ADDR_W  CPU address; stable while CpuReq
- CpuWData  in  DATA_W  CPU write data; stable while CpuReq
- CpuAck  out  1  one-cycle completion pulse
- CpuWait  out  1  combinational: CpuReq & ~CpuAck; stalls control-unit state advance
- CpuRData  out  DATA_W  last CPU read data, registered
- HostReq, HostWe, HostAddr, HostWData  in  1/1/ADDR_W/DATA_W  same rules as the CPU inputs
- HostLock  in  1  when high, CPU is never granted
- HostAck  out  1  one-cycle completion pulse
- HostRData  out  DATA_W  last HOST read data, registered
- MemEn, MemWe  out  1  RAM enable / write enable
- MemAddr, MemWData  out  ADDR_W/DATA_W  RAM address / write data, registered
- MemRData  in  DATA_W  RAM read data, valid the cycle after MemEn with MemWe=0
- BusOwner  out  1  0 = CPU, 1 = HOST; owner of the current or last transaction

## Operation
- States: IDLE, ISSUE, DONE. Owner register selects the active port.
- CPU eligible = CpuReq & ~HostLock; HOST eligible = HostReq.
- IDLE: if any port is eligible, grant. On a tie, HOST_PRIORITY decides. Latch the winner's We/Addr/WData into MemWe/MemAddr/MemWData, set the owner, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: MemEn=1. The RAM performs the write, or samples the read address, at the end of the cycle. Always go to DONE.
- DONE: MemEn=0. Assert the owner's Ack. On a read, load MemRData into the owner's RData register at the end of the cycle. Then arbitrate among the non-owner port only:
  - if the non-owner is eligible, grant it and go to ISSUE;
  - else go to IDLE.
  - The acked port's Req is ignored this cycle because it still refers to the completed access.
- Access cost: 2 cycles when alternating ports; 3 cycles for back-to-back accesses from the same port (DONE→IDLE→ISSUE).
- HostLock rising during a CPU transaction does not abort it; the transaction completes normally, and later CPU requests wait.
- A requester dropping Req before its Ack is a protocol violation; the in-flight transaction still completes and acks.
- Unowned RData registers never change. Writes never change either RData register.
- Reset value of every output: 0. This covers CpuAck, HostAck, MemEn, MemWe, MemAddr, MemWData, CpuRData, HostRData and BusOwner. State resets to IDLE.

## Timing
- Request to Ack latency from IDLE: Req seen high in cycle t → ISSUE in t+1 → Ack in t+2.
- RData is valid from cycle t+3 and holds until that port's next read completes. The control unit consumes it in the state after the ack (LW2/POP2).
- CpuWait is combinational, high in cycles t..t+1 and low in t+2 (the ack cycle).
- Reset mid-transaction: at the edge where Reset=1, state goes to IDLE and all outputs clear the next cycle. No Ack is issued for the aborted access. A write in ISSUE may or may not have reached the RAM.
- Simultaneous Req in DONE from both ports: only the non-owner is considered, so ports strictly alternate under continuous load.

## Test plan
- CPU read alone: RAM[0x0010]=0xBEEF, CpuReq=1, CpuWe=0, CpuAddr=0x0010 at t → MemEn=1 at t+1, CpuAck=1 at t+2, CpuRData=0xBEEF from t+3, HostRData stays 0.
- HOST write then CPU read: host writes 0x1234 to 0x0020 → HostAck 2 cycles after request; a subsequent CPU read of 0x0020 returns 0x1234.
- Contention with HOST_PRIORITY=0: both request in the same IDLE cycle → CPU ISSUE, CpuAck, then HOST ISSUE immediately (no IDLE cycle), HostAck 2 cycles after CpuAck. With HOST_PRIORITY=1 the order reverses.
- Back-to-back CPU reads: CpuReq held with the address changed after the ack → acks exactly 3 cycles apart; CpuWait is low only in the ack cycles.
- HostLock=1 with both requesting continuously → only HostAck pulses, spaced 3 cycles apart; CpuWait stays high. Dropping HostLock → CPU is granted at the next arbitration.
- Reset asserted during ISSUE of a CPU read → next cycle all outputs are 0 and state is IDLE. No CpuAck occurs. A request re-presented after Reset deasserts completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, the HOST loader/debug port and the shared RAM.
// slave = arbiter view, master = requester/RAM environment view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              CpuReq;
   logic              CpuWe;
   logic [ADDR_W-1:0] CpuAddr;
   logic [DATA_W-1:0] CpuWData;
   logic              CpuAck;
   logic              CpuWait;
   logic [DATA_W-1:0] CpuRData;

   logic              HostReq;
   logic              HostWe;
   logic [ADDR_W-1:0] HostAddr;
   logic [DATA_W-1:0] HostWData;
   logic              HostLock;
   logic              HostAck;
   logic [DATA_W-1:0] HostRData;

   logic              MemEn;
   logic              MemWe;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemWData;
   logic [DATA_W-1:0] MemRData;

   logic              BusOwner;

   modport slave (
      input  CpuReq, CpuWe, CpuAddr, CpuWData,
      output CpuAck, CpuWait, CpuRData,
      input  HostReq, HostWe, HostAddr, HostWData, HostLock,
      output HostAck, HostRData,
      output MemEn, MemWe, MemAddr, MemWData,
      input  MemRData,
      output BusOwner
   );

   modport master (
      output CpuReq, CpuWe, CpuAddr, CpuWData,
      input  CpuAck, CpuWait, CpuRData,
      output HostReq, HostWe, HostAddr, HostWData, HostLock,
      input  HostAck, HostRData,
      input  MemEn, MemWe, MemAddr, MemWData,
      output MemRData,
      input  BusOwner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port instruction/data RAM (CPU vs HOST),
// issuing each access as ISSUE/DONE against a one-cycle-latency block RAM.
//
// state | meaning
// IDLE  | no access in flight; arbitrate both ports, HOST_PRIORITY breaks ties
// ISSUE | MemEn high; RAM writes or samples the read address at cycle end
// DONE  | owner acked, read data captured; hand over to the other port if it waits
module mem_port_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter bit HOST_PRIORITY = 1'b0
) (
   input  logic              CLK,
   input  logic              Reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t            state, state_nxt;
   logic              owner;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic [DATA_W-1:0] host_rdata;
   logic              cpu_elig, host_elig;
   logic              grant, grant_host;

   assign cpu_elig  = bus.CpuReq & ~bus.HostLock;
   assign host_elig = bus.HostReq;

   always_ff @(posedge CLK) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      grant_host = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_elig || host_elig) begin
               grant      = 1'b1;
               grant_host = host_elig && (!cpu_elig || HOST_PRIORITY);
               state_nxt  = ISSUE;
            end
         end
         ISSUE: state_nxt = DONE;
         DONE: begin
            // the owner's Req still names the access just acked, so only the other port competes
            state_nxt = IDLE;
            if (owner) begin
               if (cpu_elig) begin
                  grant     = 1'b1;
                  state_nxt = ISSUE;
               end
            end else if (host_elig) begin
               grant      = 1'b1;
               grant_host = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         owner      <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rdata  <= '0;
         host_rdata <= '0;
      end else begin
         if (grant) begin
            owner     <= grant_host;
            mem_we    <= grant_host ? bus.HostWe    : bus.CpuWe;
            mem_addr  <= grant_host ? bus.HostAddr  : bus.CpuAddr;
            mem_wdata <= grant_host ? bus.HostWData : bus.CpuWData;
         end
         if (state == DONE && !mem_we) begin
            if (owner) host_rdata <= bus.MemRData;
            else       cpu_rdata  <= bus.MemRData;
         end
      end
   end

   assign bus.MemEn     = (state == ISSUE);
   assign bus.MemWe     = mem_we;
   assign bus.MemAddr   = mem_addr;
   assign bus.MemWData  = mem_wdata;
   assign bus.CpuAck    = (state == DONE) && !owner;
   assign bus.HostAck   = (state == DONE) && owner;
   assign bus.CpuWait   = bus.CpuReq & ~bus.CpuAck;
   assign bus.CpuRData  = cpu_rdata;
   assign bus.HostRData = host_rdata;
   assign bus.BusOwner  = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single transactions from a vector table,
// then contention, back-to-back, HostLock and mid-transaction reset sequences.
module tb_mem_port_arbiter;

   logic CLK;
   logic Reset;
   logic ram_clear;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .HOST_PRIORITY(1'b0)) dut_a (
      .CLK(CLK), .Reset(Reset), .bus(ifa.slave));
   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .HOST_PRIORITY(1'b1)) dut_b (
      .CLK(CLK), .Reset(Reset), .bus(ifb.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // second instance sees the same requesters
   always_comb begin
      ifb.CpuReq    = ifa.CpuReq;
      ifb.CpuWe     = ifa.CpuWe;
      ifb.CpuAddr   = ifa.CpuAddr;
      ifb.CpuWData  = ifa.CpuWData;
      ifb.HostReq   = ifa.HostReq;
      ifb.HostWe    = ifa.HostWe;
      ifb.HostAddr  = ifa.HostAddr;
      ifb.HostWData = ifa.HostWData;
      ifb.HostLock  = ifa.HostLock;
   end

   logic [15:0] ram_a [0:255];
   logic [15:0] ram_b [0:255];

   always @(posedge CLK) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram_a[i] <= 16'h0;
         ram_a[8'h10] <= 16'hBEEF;
      end else if (ifa.MemEn) begin
         if (ifa.MemWe) ram_a[ifa.MemAddr[7:0]] <= ifa.MemWData;
         else           ifa.MemRData <= ram_a[ifa.MemAddr[7:0]];
      end
   end

   always @(posedge CLK) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram_b[i] <= 16'h0;
         ram_b[8'h10] <= 16'hBEEF;
      end else if (ifb.MemEn) begin
         if (ifb.MemWe) ram_b[ifb.MemAddr[7:0]] <= ifb.MemWData;
         else           ifb.MemRData <= ram_b[ifb.MemAddr[7:0]];
      end
   end

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_cpu  = 16'h0;
   logic [15:0] exp_host = 16'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cpuack"},  ifa.CpuAck,    0);
      chk({tag, "_hostack"}, ifa.HostAck,   0);
      chk({tag, "_memen"},   ifa.MemEn,     0);
      chk({tag, "_memwe"},   ifa.MemWe,     0);
      chk({tag, "_memaddr"}, ifa.MemAddr,   0);
      chk({tag, "_memwd"},   ifa.MemWData,  0);
      chk({tag, "_cpurd"},   ifa.CpuRData,  0);
      chk({tag, "_hostrd"},  ifa.HostRData, 0);
      chk({tag, "_owner"},   ifa.BusOwner,  0);
   endtask

   typedef struct {
      bit          host;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rd;
   } vec_t;

   vec_t vecs [8];

   task automatic do_txn(input vec_t v);
      int n;
      bit got;
      @(posedge CLK); #1;
      if (v.host) begin
         ifa.HostReq = 1'b1; ifa.HostWe = v.we; ifa.HostAddr = v.addr; ifa.HostWData = v.wdata;
      end else begin
         ifa.CpuReq = 1'b1; ifa.CpuWe = v.we; ifa.CpuAddr = v.addr; ifa.CpuWData = v.wdata;
      end
      n = 0;
      got = 0;
      while (!got && n < 10) begin
         @(negedge CLK);
         n++;
         chk("txn_cpuwait", ifa.CpuWait, (!v.host && n < 3));
         if (n == 2) begin
            chk("txn_issue_en", ifa.MemEn, 1);
            chk("txn_issue_addr", ifa.MemAddr, v.addr);
            chk("txn_issue_we", ifa.MemWe, v.we);
         end
         if (v.host ? ifa.HostAck : ifa.CpuAck) begin
            got = 1;
            ifa.HostReq = 1'b0;
            ifa.CpuReq  = 1'b0;
         end
      end
      chk("txn_ack_cycle", n, 3);
      @(negedge CLK);
      if (!v.we) begin
         if (v.host) exp_host = v.rd;
         else        exp_cpu  = v.rd;
      end
      chk("txn_cpu_rdata", ifa.CpuRData, exp_cpu);
      chk("txn_host_rdata", ifa.HostRData, exp_host);
      chk("txn_owner", ifa.BusOwner, v.host);
   endtask

   initial begin
      int ca_a, ha_a, ca_b, ha_b, k, n, cpu_first;
      int ack_at [4];
      logic [15:0] addr_list [3];

      vecs[0] = '{host: 0, we: 0, addr: 16'h0010, wdata: 16'h0000, rd: 16'hBEEF};
      vecs[1] = '{host: 1, we: 1, addr: 16'h0020, wdata: 16'h1234, rd: 16'h0000};
      vecs[2] = '{host: 0, we: 0, addr: 16'h0020, wdata: 16'h0000, rd: 16'h1234};
      vecs[3] = '{host: 1, we: 0, addr: 16'h0010, wdata: 16'h0000, rd: 16'hBEEF};
      vecs[4] = '{host: 0, we: 1, addr: 16'h0030, wdata: 16'hA5A5, rd: 16'h0000};
      vecs[5] = '{host: 1, we: 0, addr: 16'h0030, wdata: 16'h0000, rd: 16'hA5A5};
      vecs[6] = '{host: 0, we: 0, addr: 16'h0030, wdata: 16'h0000, rd: 16'hA5A5};
      vecs[7] = '{host: 0, we: 1, addr: 16'h0040, wdata: 16'h0F0F, rd: 16'h0000};

      Reset = 1'b1; ram_clear = 1'b1;
      ifa.CpuReq = 0; ifa.CpuWe = 0; ifa.CpuAddr = 0; ifa.CpuWData = 0;
      ifa.HostReq = 0; ifa.HostWe = 0; ifa.HostAddr = 0; ifa.HostWData = 0; ifa.HostLock = 0;
      repeat (3) @(negedge CLK);
      chk_all_zero("rst");
      chk("rst_cpuwait", ifa.CpuWait, 0);
      Reset = 1'b0; ram_clear = 1'b0;

      foreach (vecs[i]) do_txn(vecs[i]);

      // contention: A grants CPU first, B grants HOST first, then strict alternation
      @(posedge CLK); #1;
      ifa.CpuReq = 1; ifa.CpuWe = 0; ifa.CpuAddr = 16'h0010;
      ifa.HostReq = 1; ifa.HostWe = 0; ifa.HostAddr = 16'h0020;
      ca_a = 0; ha_a = 0; ca_b = 0; ha_b = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         if (ifa.CpuAck && ca_a == 0)  ca_a = c;
         if (ifa.HostAck && ha_a == 0) ha_a = c;
         if (ifb.CpuAck && ca_b == 0)  ca_b = c;
         if (ifb.HostAck && ha_b == 0) ha_b = c;
         if (c == 4) begin
            chk("cont_no_idle_en", ifa.MemEn, 1);
            chk("cont_no_idle_owner", ifa.BusOwner, 1);
         end
         if (c == 5) begin ifa.CpuReq = 0; ifa.HostReq = 0; end
      end
      chk("cont_p0_cpuack", ca_a, 3);
      chk("cont_p0_hostack", ha_a, 5);
      chk("cont_p1_hostack", ha_b, 3);
      chk("cont_p1_cpuack", ca_b, 5);
      exp_cpu = 16'hBEEF; exp_host = 16'h1234;
      chk("cont_cpu_rdata", ifa.CpuRData, exp_cpu);
      chk("cont_host_rdata", ifa.HostRData, exp_host);
      chk("cont_p1_cpu_rdata", ifb.CpuRData, 16'hBEEF);
      chk("cont_p1_host_rdata", ifb.HostRData, 16'h1234);

      // back-to-back CPU reads, address changed in each ack cycle
      addr_list[0] = 16'h0010; addr_list[1] = 16'h0020; addr_list[2] = 16'h0030;
      @(posedge CLK); #1;
      ifa.CpuReq = 1; ifa.CpuWe = 0; ifa.CpuAddr = addr_list[0];
      k = 0;
      for (int i = 0; i < 4; i++) ack_at[i] = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         if (k < 3) chk("b2b_wait", ifa.CpuWait, !(c == 3 || c == 6 || c == 9));
         if (ifa.CpuAck && k < 3) begin
            ack_at[k] = c;
            k++;
            if (k < 3) ifa.CpuAddr = addr_list[k];
            else       ifa.CpuReq  = 0;
         end
      end
      chk("b2b_ack0", ack_at[0], 3);
      chk("b2b_ack1", ack_at[1], 6);
      chk("b2b_ack2", ack_at[2], 9);
      exp_cpu = 16'hA5A5;
      chk("b2b_rdata", ifa.CpuRData, exp_cpu);

      // HostLock: only HOST served until the lock drops
      @(posedge CLK); #1;
      ifa.HostLock = 1;
      ifa.CpuReq = 1; ifa.CpuWe = 0; ifa.CpuAddr = 16'h0010;
      ifa.HostReq = 1; ifa.HostWe = 0; ifa.HostAddr = 16'h0020;
      k = 0; cpu_first = 0;
      for (int i = 0; i < 4; i++) ack_at[i] = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge CLK);
         if (cpu_first == 0) chk("lock_cpuwait", ifa.CpuWait, (c != 14));
         if (ifa.CpuAck && cpu_first == 0) begin
            cpu_first = c;
            ifa.CpuReq = 0;
         end
         if (ifa.HostAck && k < 4) begin
            ack_at[k] = c;
            k++;
            if (k == 4) begin ifa.HostReq = 0; ifa.HostLock = 0; end
         end
      end
      chk("lock_host_acks", k, 4);
      chk("lock_hack0", ack_at[0], 3);
      chk("lock_hack1", ack_at[1], 6);
      chk("lock_hack2", ack_at[2], 9);
      chk("lock_hack3", ack_at[3], 12);
      chk("lock_cpu_after_unlock", cpu_first, 14);
      exp_cpu = 16'hBEEF;
      chk("lock_cpu_rdata", ifa.CpuRData, exp_cpu);
      chk("lock_host_rdata", ifa.HostRData, exp_host);

      // reset during ISSUE of a CPU read, then re-present the request
      @(posedge CLK); #1;
      ifa.CpuReq = 1; ifa.CpuWe = 0; ifa.CpuAddr = 16'h0020;
      @(negedge CLK);
      @(negedge CLK);
      chk("rmid_issue_en", ifa.MemEn, 1);
      Reset = 1'b1;
      @(negedge CLK);
      chk_all_zero("rmid");
      exp_cpu = 16'h0; exp_host = 16'h0;
      Reset = 1'b0;
      n = 0;
      while (n < 10 && !ifa.CpuAck) begin
         @(negedge CLK);
         n++;
      end
      chk("rmid_reack_cycle", n, 2);
      ifa.CpuReq = 0;
      @(negedge CLK);
      exp_cpu = 16'h1234;
      chk("rmid_cpu_rdata", ifa.CpuRData, exp_cpu);
      chk("rmid_host_rdata", ifa.HostRData, exp_host);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
